timer_scheduler: RTL and testbench
==================================

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, number of alarm channels (2..8).
REQ-002 SHALL have parameter TW, default 16, width of delay and time counters.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tick  input  1  one-cycle time-base pulse from the divider; one pulse = one time unit.
REQ-006 SHALL have ports wr_en/wr_ch/wr_delay/wr_periodic  input  1/log2(NCH)/TW/1  arm command.
REQ-007 SHALL have ports cancel_en/cancel_ch  input  1/log2(NCH)  disarm command.
REQ-008 SHALL have ports ack_en/ack_ch  input  1/log2(NCH)  interrupt acknowledge.
REQ-009 SHALL have port time_now  output  TW  free-running tick count.
REQ-010 SHALL have ports armed/pending/overrun  output  NCH each  per-channel status.
REQ-011 SHALL have ports irq/irq_ch  output  1/log2(NCH)  scheduled interrupt and the channel it names.

Function
REQ-012 Each channel SHALL be in exactly one state: IDLE, ARMED or FIRED; armed[i]=1 in ARMED, and in FIRED when periodic.
REQ-013 time_now SHALL increment by 1 on each clock with tick=1 and wrap from 2^TW-1 to 0.
REQ-014 On wr_en, channel wr_ch SHALL load remaining=wr_delay and reload=wr_delay, latch wr_periodic, and enter ARMED; a write to an ARMED channel restarts it.
REQ-015 A write with wr_delay=0 SHALL set the channel FIRED/pending at that same edge (latency 1 clock).
REQ-016 An ARMED channel SHALL decrement remaining on each tick and SHALL fire on the tick where remaining goes 1->0, i.e. exactly wr_delay ticks after arming.
REQ-017 A tick coinciding with the arming write SHALL NOT decrement the newly loaded value.
REQ-018 On firing, pending[i] SHALL set; a one-shot channel enters FIRED; a periodic channel reloads remaining=reload and keeps counting.
REQ-019 A periodic channel that expires while pending[i]=1 SHALL set overrun[i] (sticky) and keep pending[i]=1.
REQ-020 On ack_en, channel ack_ch SHALL clear pending[i] and overrun[i]; one-shot FIRED goes IDLE; ack of a non-pending channel is ignored.
REQ-021 cancel_en SHALL force channel cancel_ch to IDLE and clear pending[i] and overrun[i].
REQ-022 Same-cycle priority on one channel SHALL be write > cancel > ack > expiry.
REQ-023 irq SHALL equal OR of pending; irq_ch SHALL name one pending channel, chosen round-robin starting after the last acknowledged channel.
REQ-024 irq_ch SHALL stay stable while its channel remains pending and re-arbitrate only on the clock after that channel is cleared.
REQ-025 Commands to different channels in the same cycle SHALL all take effect.

Reset
REQ-026 rst SHALL asynchronously force all channels IDLE and set time_now=0, armed=0, pending=0, overrun=0, irq=0, irq_ch=0 and the round-robin pointer to 0.
REQ-027 rst asserted mid-count SHALL discard all remaining counts; no channel fires after deassertion until re-armed.

Structure
REQ-028 Channel state enum, default NCH and TW SHALL reside in a shared timer package.
REQ-029 Per-channel counter/FSM SHALL be sub-module timer_channel, instantiated NCH times; arbiter and time_now stay in the top.

Verification
REQ-030 Arm ch0 delay=3 one-shot, ticks every 10 clocks -> pending[0] rises on the 3rd tick edge, irq=1, irq_ch=0; ack -> IDLE, irq=0.
REQ-031 Arm ch1 delay=0 -> pending[1]=1 one clock after write; arm ch2 delay=5 with tick in the same cycle -> fires on the 5th later tick.
REQ-032 Arm ch3 periodic delay=2, never ack -> pending at tick 2, overrun[3]=1 at tick 4; ack clears both, next pending at tick 6.
REQ-033 ch0 and ch2 fire together -> irq_ch=0; ack 0 -> irq_ch=2 next clock; both re-fire together -> irq_ch=2 first (round-robin).
REQ-034 Arm ch1 delay=4, cancel after tick 2 -> no fire; write+cancel same cycle on ch1 -> ARMED.
REQ-035 4 channels armed, rst pulsed mid-count -> all outputs 0, time_now=0, no fire over 20 later ticks; also 2^TW ticks -> time_now wraps to 0.

Source files
------------

// File: rtl/timer_scheduler_pkg.sv
// Shared definitions for the alarm-channel timer scheduler.
package timer_scheduler_pkg;

  localparam int unsigned NCH_DEFAULT = 4;
  localparam int unsigned TW_DEFAULT  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StFired
  } ch_state_e;

endpackage

// File: rtl/timer_scheduler_if.sv
// Command and status bundle between a host and the timer scheduler.
interface timer_scheduler_if
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT,
  parameter int unsigned TW  = TW_DEFAULT
);
  localparam int unsigned CW = $clog2(NCH);

  logic          tick;
  logic          wr_en;
  logic [CW-1:0] wr_ch;
  logic [TW-1:0] wr_delay;
  logic          wr_periodic;
  logic          cancel_en;
  logic [CW-1:0] cancel_ch;
  logic          ack_en;
  logic [CW-1:0] ack_ch;

  logic [TW-1:0]  time_now;
  logic [NCH-1:0] armed;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] overrun;
  logic           irq;
  logic [CW-1:0]  irq_ch;

  modport master (
    output tick, wr_en, wr_ch, wr_delay, wr_periodic, cancel_en, cancel_ch, ack_en, ack_ch,
    input  time_now, armed, pending, overrun, irq, irq_ch
  );

  modport slave (
    input  tick, wr_en, wr_ch, wr_delay, wr_periodic, cancel_en, cancel_ch, ack_en, ack_ch,
    output time_now, armed, pending, overrun, irq, irq_ch
  );

endinterface

// File: rtl/timer_channel.sv
// One alarm channel: countdown in time-base ticks, one-shot or periodic, with pending/overrun flags.
module timer_channel
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned TW = TW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          wr,
  input  logic [TW-1:0] wr_delay,
  input  logic          wr_periodic,
  input  logic          cancel,
  input  logic          ack,
  output logic          armed,
  output logic          pending,
  output logic          overrun
);

  ch_state_e     state_q;
  logic [TW-1:0] remaining_q;
  logic [TW-1:0] reload_q;
  logic          periodic_q;
  logic          pending_q;
  logic          overrun_q;
  logic          ack_hit;

  assign ack_hit = ack && pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      reload_q    <= '0;
      periodic_q  <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (wr) begin
      remaining_q <= wr_delay;
      reload_q    <= wr_delay;
      periodic_q  <= wr_periodic;
      overrun_q   <= 1'b0;
      if (wr_delay == '0) begin
        state_q   <= StFired;
        pending_q <= 1'b1;
      end else begin
        state_q   <= StArmed;
        pending_q <= 1'b0;
      end
    end else if (cancel) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (ack_hit) begin
        pending_q <= 1'b0;
        overrun_q <= 1'b0;
        if (state_q == StFired) state_q <= StIdle;
      end
      if (state_q == StArmed && tick) begin
        if (remaining_q == TW'(1)) begin
          // An acknowledge in the same cycle outranks the expiry's flag update.
          if (!ack_hit) begin
            pending_q <= 1'b1;
            if (pending_q && periodic_q) overrun_q <= 1'b1;
          end
          if (periodic_q) begin
            remaining_q <= reload_q;
          end else begin
            remaining_q <= '0;
            state_q     <= StFired;
          end
        end else begin
          remaining_q <= remaining_q - TW'(1);
        end
      end
    end
  end

  assign armed   = (state_q == StArmed) || (state_q == StFired && periodic_q);
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel alarm scheduler: free-running time base, NCH channels, round-robin irq selection.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT,
  parameter int unsigned TW  = TW_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  timer_scheduler_if.slave bus
);

  localparam int unsigned CW = $clog2(NCH);

  logic [TW-1:0]  time_q;
  logic [NCH-1:0] armed;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] overrun;
  logic [CW-1:0]  ptr_q;
  logic [CW-1:0]  cur_q;
  logic           held_q;
  logic [CW-1:0]  sel;
  logic [CW-1:0]  idx;
  logic           found;
  logic           ack_hit;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    timer_channel #(
      .TW(TW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (bus.tick),
      .wr         (bus.wr_en && (bus.wr_ch == CW'(i))),
      .wr_delay   (bus.wr_delay),
      .wr_periodic(bus.wr_periodic),
      .cancel     (bus.cancel_en && (bus.cancel_ch == CW'(i))),
      .ack        (bus.ack_en && (bus.ack_ch == CW'(i))),
      .armed      (armed[i]),
      .pending    (pending[i]),
      .overrun    (overrun[i])
    );
  end

  // Only an acknowledge that actually clears a flag moves the round-robin start point.
  assign ack_hit = bus.ack_en && pending[bus.ack_ch]
                && !(bus.wr_en && (bus.wr_ch == bus.ack_ch))
                && !(bus.cancel_en && (bus.cancel_ch == bus.ack_ch));

  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    if (held_q && pending[cur_q]) begin
      sel = cur_q;
    end else begin
      for (int k = 0; k < int'(NCH); k++) begin
        idx = CW'((int'(ptr_q) + k) % int'(NCH));
        if (!found && pending[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q <= '0;
      ptr_q  <= '0;
      cur_q  <= '0;
      held_q <= 1'b0;
    end else begin
      if (bus.tick) time_q <= time_q + TW'(1);
      cur_q  <= sel;
      held_q <= |pending;
      if (ack_hit) ptr_q <= (bus.ack_ch == CW'(NCH - 1)) ? '0 : bus.ack_ch + CW'(1);
    end
  end

  assign bus.time_now = time_q;
  assign bus.armed    = armed;
  assign bus.pending  = pending;
  assign bus.overrun  = overrun;
  assign bus.irq      = |pending;
  assign bus.irq_ch   = sel;

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: directed scenarios plus random traffic against a deadline model.
module tb_timer_scheduler;

  localparam int unsigned NCH = 4;
  localparam int unsigned TW  = 8;
  localparam int unsigned CW  = 2;
  localparam int SI = 0, SA = 1, SF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timer_scheduler_if #(.NCH(NCH), .TW(TW)) bus ();

  timer_scheduler #(.NCH(NCH), .TW(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: absolute tick count, per-channel absolute deadline in ticks.
  int m_t;
  int m_st [NCH];
  int m_dl [NCH];
  int m_rel[NCH];
  bit m_per [NCH];
  bit m_pend[NCH];
  bit m_ovr [NCH];
  int m_ptr;
  int m_disp;
  bit m_irq;

  function automatic logic [NCH-1:0] v_pend();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
    return v;
  endfunction

  function automatic logic [NCH-1:0] v_ovr();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_ovr[c];
    return v;
  endfunction

  function automatic logic [NCH-1:0] v_armed();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (m_st[c] == SA) || (m_st[c] == SF && m_per[c]);
    return v;
  endfunction

  function automatic int pick(logic [NCH-1:0] p, int ptr);
    for (int k = 0; k < NCH; k++) if (p[(ptr + k) % NCH]) return (ptr + k) % NCH;
    return 0;
  endfunction

  task automatic model_reset();
    m_t = 0; m_ptr = 0; m_disp = 0; m_irq = 0;
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = SI; m_dl[c] = 0; m_rel[c] = 0; m_per[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
    end
  endtask

  task automatic model_edge();
    int nt;
    logic [NCH-1:0] pv;
    nt = m_t + (bus.tick ? 1 : 0);
    for (int c = 0; c < NCH; c++) begin
      bit w, cn, ak, fire;
      w  = bus.wr_en && (int'(bus.wr_ch) == c);
      cn = bus.cancel_en && (int'(bus.cancel_ch) == c);
      ak = bus.ack_en && (int'(bus.ack_ch) == c) && m_pend[c];
      if (w) begin
        m_rel[c] = int'(bus.wr_delay);
        m_per[c] = bus.wr_periodic;
        m_ovr[c] = 0;
        if (bus.wr_delay == 0) begin
          m_st[c] = SF; m_pend[c] = 1;
        end else begin
          m_st[c] = SA; m_pend[c] = 0; m_dl[c] = nt + m_rel[c];
        end
      end else if (cn) begin
        m_st[c] = SI; m_pend[c] = 0; m_ovr[c] = 0;
      end else begin
        fire = (m_st[c] == SA) && bus.tick && (nt == m_dl[c]);
        if (ak) begin
          m_pend[c] = 0; m_ovr[c] = 0; m_ptr = (c + 1) % NCH;
          if (m_st[c] == SF) m_st[c] = SI;
        end
        if (fire) begin
          if (!ak) begin
            if (m_pend[c] && m_per[c]) m_ovr[c] = 1;
            m_pend[c] = 1;
          end
          if (m_per[c]) m_dl[c] = m_dl[c] + m_rel[c];
          else m_st[c] = SF;
        end
      end
    end
    m_t = nt;
    pv = v_pend();
    m_disp = (m_irq && pv[m_disp]) ? m_disp : pick(pv, m_ptr);
    m_irq = |pv;
  endtask

  task automatic drive_idle();
    bus.tick = 0; bus.wr_en = 0; bus.wr_ch = '0; bus.wr_delay = '0; bus.wr_periodic = 0;
    bus.cancel_en = 0; bus.cancel_ch = '0; bus.ack_en = 0; bus.ack_ch = '0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic tick_once();
    bus.tick = 1;
    step();
  endtask

  task automatic arm(int ch, int dly, bit per);
    bus.wr_en = 1; bus.wr_ch = CW'(ch); bus.wr_delay = TW'(dly); bus.wr_periodic = per;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    model_reset();
    #12;
    total++; if (bus.time_now !== '0) begin bad++; $display("FAIL reset_time: got %0h want 0", bus.time_now); end
    total++; if (bus.armed !== '0) begin bad++; $display("FAIL reset_armed: got %b want 0", bus.armed); end
    total++; if (bus.pending !== '0) begin bad++; $display("FAIL reset_pending: got %b want 0", bus.pending); end
    total++; if (bus.overrun !== '0) begin bad++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    total++; if (bus.irq_ch !== '0) begin bad++; $display("FAIL reset_irq_ch: got %0d want 0", bus.irq_ch); end
    @(posedge clk);
    #1;
    rst = 0;
    idle(2);
    total++; if (bus.time_now !== '0) begin bad++; $display("FAIL reset_notick: got %0h want 0", bus.time_now); end
  endtask

  task automatic test_oneshot();
    arm(0, 3, 0);
    step();
    total++; if (bus.armed[0] !== 1'b1) begin bad++; $display("FAIL os_armed: got %b want 1", bus.armed[0]); end
    for (int k = 1; k <= 3; k++) begin
      idle(9);
      tick_once();
      total++;
      if (bus.pending[0] !== (k == 3)) begin
        bad++; $display("FAIL os_pending_tick%0d: got %b want %b", k, bus.pending[0], (k == 3));
      end
    end
    total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL os_irq: got %b want 1", bus.irq); end
    total++; if (bus.irq_ch !== 2'd0) begin bad++; $display("FAIL os_irq_ch: got %0d want 0", bus.irq_ch); end
    total++; if (bus.armed[0] !== 1'b0) begin bad++; $display("FAIL os_fired_armed: got %b want 0", bus.armed[0]); end
    bus.ack_en = 1; bus.ack_ch = 2'd0;
    step();
    total++; if (bus.pending !== '0 || bus.irq !== 1'b0) begin
      bad++; $display("FAIL os_ack: got pending=%b irq=%b want 0/0", bus.pending, bus.irq);
    end
    total++; if (bus.time_now !== TW'(m_t)) begin bad++; $display("FAIL os_time: got %0d want %0d", bus.time_now, m_t); end
  endtask

  task automatic test_zero_delay();
    arm(1, 0, 0);
    step();
    total++; if (bus.pending[1] !== 1'b1) begin bad++; $display("FAIL zd_pending: got %b want 1", bus.pending[1]); end
    total++; if (bus.irq_ch !== 2'd1) begin bad++; $display("FAIL zd_irq_ch: got %0d want 1", bus.irq_ch); end
    bus.ack_en = 1; bus.ack_ch = 2'd1;
    step();
    arm(2, 5, 0);
    bus.tick = 1;
    step();
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      tick_once();
      total++;
      if (bus.pending[2] !== (k == 5)) begin
        bad++; $display("FAIL zd_coincide_tick%0d: got %b want %b", k, bus.pending[2], (k == 5));
      end
    end
    bus.ack_en = 1; bus.ack_ch = 2'd2;
    step();
  endtask

  task automatic test_periodic();
    logic [5:0] exp_p, exp_o;
    exp_p = 6'b101110;
    exp_o = 6'b001000;
    arm(3, 2, 1);
    step();
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) begin
        bus.ack_en = 1; bus.ack_ch = 2'd3;
        step();
        total++; if (bus.pending[3] !== 1'b0 || bus.overrun[3] !== 1'b0 || bus.armed[3] !== 1'b1) begin
          bad++; $display("FAIL per_ack: got p=%b o=%b a=%b want 0/0/1",
                          bus.pending[3], bus.overrun[3], bus.armed[3]);
        end
      end
      tick_once();
      total++; if (bus.pending[3] !== exp_p[k-1] || bus.overrun[3] !== exp_o[k-1]) begin
        bad++; $display("FAIL per_tick%0d: got p=%b o=%b want %b/%b",
                        k, bus.pending[3], bus.overrun[3], exp_p[k-1], exp_o[k-1]);
      end
    end
    bus.cancel_en = 1; bus.cancel_ch = 2'd3;
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    arm(0, 2, 0); step();
    arm(2, 2, 0); step();
    tick_once(); tick_once();
    total++; if (bus.pending !== 4'b0101 || bus.irq_ch !== 2'd0) begin
      bad++; $display("FAIL rr_first: got p=%b ch=%0d want 0101/0", bus.pending, bus.irq_ch);
    end
    bus.ack_en = 1; bus.ack_ch = 2'd0;
    step();
    total++; if (bus.irq_ch !== 2'd2) begin bad++; $display("FAIL rr_after_ack0: got %0d want 2", bus.irq_ch); end
    bus.cancel_en = 1; bus.cancel_ch = 2'd2;
    step();
    arm(0, 1, 0); step();
    arm(2, 1, 0); step();
    tick_once();
    total++; if (bus.pending !== 4'b0101 || bus.irq_ch !== 2'd2) begin
      bad++; $display("FAIL rr_refire: got p=%b ch=%0d want 0101/2", bus.pending, bus.irq_ch);
    end
    bus.ack_en = 1; bus.ack_ch = 2'd2;
    step();
    total++; if (bus.irq_ch !== 2'd0) begin bad++; $display("FAIL rr_after_ack2: got %0d want 0", bus.irq_ch); end
    // Acknowledge one channel while arming another in the same cycle.
    bus.ack_en = 1; bus.ack_ch = 2'd0;
    arm(1, 0, 0);
    step();
    total++; if (bus.pending !== 4'b0010 || bus.irq_ch !== 2'd1) begin
      bad++; $display("FAIL multi_cmd: got p=%b ch=%0d want 0010/1", bus.pending, bus.irq_ch);
    end
    bus.ack_en = 1; bus.ack_ch = 2'd1;
    step();
  endtask

  task automatic test_cancel();
    arm(1, 4, 0); step();
    tick_once(); tick_once();
    bus.cancel_en = 1; bus.cancel_ch = 2'd1;
    step();
    total++; if (bus.armed[1] !== 1'b0) begin bad++; $display("FAIL cancel_armed: got %b want 0", bus.armed[1]); end
    for (int k = 0; k < 4; k++) tick_once();
    total++; if (bus.pending[1] !== 1'b0) begin bad++; $display("FAIL cancel_nofire: got %b want 0", bus.pending[1]); end
    arm(1, 3, 0);
    bus.cancel_en = 1; bus.cancel_ch = 2'd1;
    step();
    total++; if (bus.armed[1] !== 1'b1) begin bad++; $display("FAIL wr_over_cancel: got %b want 1", bus.armed[1]); end
    bus.cancel_en = 1; bus.cancel_ch = 2'd1;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    arm(0, 5, 0); step();
    arm(1, 6, 1); step();
    arm(2, 7, 0); step();
    arm(3, 8, 1); step();
    tick_once(); tick_once();
    #3;
    rst = 1;
    #1;
    total++; if ({bus.armed, bus.pending, bus.overrun} !== '0 || bus.irq !== 1'b0 || bus.time_now !== '0) begin
      bad++; $display("FAIL rst_async: got a=%b p=%b t=%0d want 0", bus.armed, bus.pending, bus.time_now);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    drive_idle();
    for (int k = 0; k < 20; k++) begin
      tick_once();
      total++; if (bus.pending !== '0 || bus.armed !== '0) begin
        bad++; $display("FAIL rst_nofire%0d: got p=%b a=%b want 0", k, bus.pending, bus.armed);
      end
    end
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      tick_once();
      if (k == 255) begin
        total++; if (bus.time_now !== 8'hFF) begin bad++; $display("FAIL time_max: got %0h want ff", bus.time_now); end
      end
    end
    total++; if (bus.time_now !== 8'h00) begin bad++; $display("FAIL time_wrap: got %0h want 0", bus.time_now); end
  endtask

  task automatic test_random();
    logic [TW-1:0] et;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.tick = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) arm($urandom_range(0, NCH - 1), $urandom_range(0, 5), $urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        bus.cancel_en = 1; bus.cancel_ch = CW'($urandom_range(0, NCH - 1));
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.ack_en = 1;
        bus.ack_ch = ($urandom_range(0, 1) == 1) ? CW'(m_disp) : CW'($urandom_range(0, NCH - 1));
      end
      step();
      et = m_t[TW-1:0];
      total++; if (bus.time_now !== et) begin bad++; $display("FAIL rnd_time@%0d: got %0d want %0d", n, bus.time_now, et); end
      total++; if (bus.armed !== v_armed()) begin bad++; $display("FAIL rnd_armed@%0d: got %b want %b", n, bus.armed, v_armed()); end
      total++; if (bus.pending !== v_pend()) begin bad++; $display("FAIL rnd_pending@%0d: got %b want %b", n, bus.pending, v_pend()); end
      total++; if (bus.overrun !== v_ovr()) begin bad++; $display("FAIL rnd_overrun@%0d: got %b want %b", n, bus.overrun, v_ovr()); end
      total++; if (bus.irq !== m_irq) begin bad++; $display("FAIL rnd_irq@%0d: got %b want %b", n, bus.irq, m_irq); end
      total++; if (bus.irq_ch !== CW'(m_disp)) begin bad++; $display("FAIL rnd_irq_ch@%0d: got %0d want %0d", n, bus.irq_ch, m_disp); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_oneshot();
    test_zero_delay();
    test_periodic();
    test_round_robin();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
